// File: rtl/dmem_ctrl.sv
// Data-memory controller: 8-byte little-endian loads/stores into an internal byte
// array, one byte per cycle, with a registered valid/ready request/response handshake.
module dmem_ctrl #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      k_q, k_d;
  logic            write_q, write_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [63:0]     rsp_rdata_q, rsp_rdata_d;

  logic [7:0]      mem_q [MEM_BYTES];
  logic            accept_c;
  logic            addr_err_c;
  logic            mem_we_c;
  logic [AW-1:0]   mem_idx_c;
  logic [7:0]      mem_wbyte_c;
  logic [7:0]      mem_rbyte_c;

  // Full 64-bit compare so huge addresses never alias into the array.
  assign addr_err_c  = (req_addr_i > MAX_ADDR);
  assign accept_c    = (state_q == IDLE) && req_valid_i && req_ready_q;
  assign mem_idx_c   = addr_q + AW'(k_q);
  assign mem_wbyte_c = wdata_q[{k_q, 3'b000} +: 8];
  assign mem_rbyte_c = mem_q[mem_idx_c];

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = addr_err_c ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (k_q == 3'd7) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    k_d         = k_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_we_c    = 1'b0;
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          write_d     = req_write_i;
          addr_d      = req_addr_i[AW-1:0];
          wdata_d     = req_wdata_i;
          k_d         = 3'd0;
          rsp_err_d   = addr_err_c;
          rsp_rdata_d = '0;
        end
      end
      ACCESS: begin
        k_d = k_q + 3'd1;
        if (write_q) begin
          mem_we_c = 1'b1;
        end else begin
          rsp_rdata_d[{k_q, 3'b000} +: 8] = mem_rbyte_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q         <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      k_q         <= k_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Byte array; reset clears every byte, which also discards an aborted store.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we_c) begin
      mem_q[mem_idx_c] <= mem_wbyte_c;
    end
  end

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a byte-array model predicts each response at
// acceptance; responses are popped and checked for data, error flag and latency.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mdl [1024];
  int         n_vec   = 0;
  int         n_err   = 0;
  int         acc_cnt = 0;
  int         acc_exp = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_BYTES(1024)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  // Count every handshake the DUT actually takes.
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a request (at a negedge), predict its response at the acceptance edge.
  task automatic send(input logic w, input logic [63:0] a, input logic [63:0] d, input logic keep);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_wait", 64'(req_ready), 64'd1);
    @(posedge clk);
    acc_exp++;
    e.err   = (a > 64'd1016);
    e.rdata = '0;
    e.lat   = e.err ? 1 : 9;
    if (!e.err) begin
      for (int i = 0; i < 8; i++) begin
        int idx;
        idx = int'(a[9:0]) + i;
        if (w) mdl[idx] = d[8*i +: 8];
        else   e.rdata[8*i +: 8] = mdl[idx];
      end
    end
    sb.push_back(e);
    @(negedge clk);
    req_valid = keep;
    req_write = ~w;
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    check_eq("accept_once", 64'(acc_cnt), 64'(acc_exp));
    check_eq("ready_after_accept", 64'(req_ready), 64'd0);
  endtask

  // Wait for the response, hold it under backpressure, then complete the handshake.
  task automatic recv(input int hold, input logic poke);
    exp_t e;
    int   lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check_eq("latency", 64'(lat), 64'(e.lat));
    check_eq("rsp_valid", 64'(rsp_valid), 64'd1);
    check_eq("rsp_rdata", rsp_rdata, e.rdata);
    check_eq("rsp_err", 64'(rsp_err), 64'(e.err));
    check_eq("ready_in_resp", 64'(req_ready), 64'd0);
    if (poke) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'h10;
      req_wdata = '1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 64'(rsp_valid), 64'd1);
      check_eq("bp_rdata", rsp_rdata, e.rdata);
      check_eq("bp_err", 64'(rsp_err), 64'(e.err));
      check_eq("bp_ready", 64'(req_ready), 64'd0);
      check_eq("bp_no_accept", 64'(acc_cnt), 64'(acc_exp));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (poke) req_valid = 1'b0;
    check_eq("post_hs_valid", 64'(rsp_valid), 64'd0);
    check_eq("post_hs_ready", 64'(req_ready), 64'd1);
    check_eq("post_hs_no_accept", 64'(acc_cnt), 64'(acc_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic        w;
    logic [63:0] a;
    for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 64'd0);
    check_eq("rst_rsp_err", 64'(rsp_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic store/load round trip and byte ordering
    send(1'b1, 64'h10, 64'h1122334455667788, 1'b0); recv(0, 1'b0);
    send(1'b0, 64'h10, 64'h0, 1'b0);                recv(0, 1'b0);
    send(1'b0, 64'h17, 64'h0, 1'b0);                recv(0, 1'b0);

    // Address boundary and wrap-around
    send(1'b1, 64'd1016, 64'h0102030405060708, 1'b0);          recv(0, 1'b0);
    send(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEADBEEFCAFEF00D, 1'b0); recv(0, 1'b0);
    send(1'b0, 64'd1016, 64'h0, 1'b0);                          recv(0, 1'b0);
    send(1'b0, 64'd1017, 64'h0, 1'b0);                          recv(0, 1'b0);
    send(1'b1, 64'h8000_0000_0000_0010, 64'h5555AAAA5555AAAA, 1'b0); recv(0, 1'b0);
    send(1'b0, 64'h10, 64'h0, 1'b0);                            recv(0, 1'b0);

    // Backpressure with a competing request that must be ignored
    send(1'b0, 64'h10, 64'h0, 1'b0); recv(5, 1'b1);
    send(1'b0, 64'h10, 64'h0, 1'b0); recv(0, 1'b0);

    // Reset in the middle of a store to 0x20
    send(1'b1, 64'h20, 64'hA1A2A3A4A5A6A7A8, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ready", 64'(req_ready), 64'd1);
    check_eq("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check_eq("mid_rst_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;
    sb.delete();
    acc_exp = acc_cnt;
    for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    send(1'b0, 64'h20, 64'h0, 1'b0); recv(0, 1'b0);
    send(1'b0, 64'h10, 64'h0, 1'b0); recv(0, 1'b0);

    // Back-to-back traffic with request valid held high throughout
    for (int t = 0; t < 10; t++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 64'd1017 + 64'($urandom_range(0, 5000));
      else                           a = 64'($urandom_range(0, 1016));
      send(w, a, {$urandom, $urandom}, 1'b1);
      recv(t % 3, 1'b0);
    end
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("final_no_accept", 64'(acc_cnt), 64'(acc_exp));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
